// File: rtl/queue_flag_tracker_if.sv
// rtl/queue_flag_tracker_if.sv - strobe/flag bundle between queue control and the occupancy tracker
//
// Purpose: groups the push/pop strobes, error clear, acceptance outputs and the
//          per-channel occupancy/flag outputs of queue_flag_tracker.
// Signals:
//   push, push_ch, pop, pop_ch, clr_err  - driven by queue control (master)
//   push_acc, pop_acc                    - combinational acceptance (slave)
//   count                                - flat occupancy, channel c at [c*(N+1) +: N+1]
//   empty, full, almost_empty, almost_full, overflow, underflow - per-channel flags
//   any_ne, sel_ch                       - lowest-index non-empty channel report
interface queue_flag_tracker_if #(
    parameter int N  = 3,
    parameter int CH = 4
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW  = N + 1;

    logic               push;
    logic [CHW-1:0]     push_ch;
    logic               pop;
    logic [CHW-1:0]     pop_ch;
    logic               clr_err;
    logic               push_acc;
    logic               pop_acc;
    logic [CH*CW-1:0]   count;
    logic [CH-1:0]      empty;
    logic [CH-1:0]      full;
    logic [CH-1:0]      almost_empty;
    logic [CH-1:0]      almost_full;
    logic [CH-1:0]      overflow;
    logic [CH-1:0]      underflow;
    logic               any_ne;
    logic [CHW-1:0]     sel_ch;

    modport master (
        output push, push_ch, pop, pop_ch, clr_err,
        input  push_acc, pop_acc, count, empty, full, almost_empty, almost_full,
               overflow, underflow, any_ne, sel_ch
    );

    modport slave (
        input  push, push_ch, pop, pop_ch, clr_err,
        output push_acc, pop_acc, count, empty, full, almost_empty, almost_full,
               overflow, underflow, any_ne, sel_ch
    );
endinterface

// File: rtl/queue_flag_tracker.sv
// rtl/queue_flag_tracker.sv - multi-channel queue occupancy counters with registered flags
//
// Purpose: per-channel occupancy counter (0..2**N) driven by push/pop strobes,
//          registered empty/full/almost flags, sticky overflow/underflow bits and
//          a lowest-index non-empty channel report for the dequeue scheduler.
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - queue_flag_tracker_if.slave (strobes in, acceptance and flags out)
module queue_flag_tracker #(
    parameter int N      = 3,
    parameter int CH     = 4,
    parameter int AF_LVL = 2**N - 1,
    parameter int AE_LVL = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    queue_flag_tracker_if.slave   bus
);
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW    = N + 1;
    localparam int DEPTH = 2**N;

    logic [CW-1:0]  cnt_q [CH];
    logic [CW-1:0]  cnt_d [CH];
    logic [CH-1:0]  empty_q, empty_d;
    logic [CH-1:0]  full_q, full_d;
    logic [CH-1:0]  ae_q, ae_d;
    logic [CH-1:0]  af_q, af_d;
    logic [CH-1:0]  ovf_q, ovf_d;
    logic [CH-1:0]  unf_q, unf_d;
    logic           any_ne_q, any_ne_d;
    logic [CHW-1:0] sel_q, sel_d;

    logic           push_in, pop_in;
    logic [CHW-1:0] push_idx, pop_idx;
    logic           push_acc, pop_acc;

    // Out-of-range channel strobes are dropped silently; the index is forced
    // to 0 so the array reads stay in bounds.
    assign push_in  = int'(bus.push_ch) < CH;
    assign pop_in   = int'(bus.pop_ch) < CH;
    assign push_idx = push_in ? bus.push_ch : '0;
    assign pop_idx  = pop_in ? bus.pop_ch : '0;

    assign pop_acc  = bus.pop && pop_in && (cnt_q[pop_idx] != '0);
    // A full channel still takes a push when it is drained in the same cycle.
    assign push_acc = bus.push && push_in &&
                      ((cnt_q[push_idx] != CW'(DEPTH)) ||
                       (pop_acc && (pop_idx == push_idx)));

    assign bus.push_acc = push_acc;
    assign bus.pop_acc  = pop_acc;

    always_comb begin
        empty_d  = '0;
        full_d   = '0;
        ae_d     = '0;
        af_d     = '0;
        sel_d    = '0;
        any_ne_d = 1'b0;
        ovf_d    = bus.clr_err ? '0 : ovf_q;
        unf_d    = bus.clr_err ? '0 : unf_q;
        for (int c = 0; c < CH; c++) begin
            logic inc, dec;
            inc      = push_acc && (push_idx == CHW'(c));
            dec      = pop_acc && (pop_idx == CHW'(c));
            cnt_d[c] = cnt_q[c];
            if (inc && !dec) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
            empty_d[c] = (cnt_d[c] == '0);
            full_d[c]  = (cnt_d[c] == CW'(DEPTH));
            ae_d[c]    = int'(cnt_d[c]) <= AE_LVL;
            af_d[c]    = int'(cnt_d[c]) >= AF_LVL;
        end
        // New errors are applied after the clear so they survive a same-cycle clr_err.
        if (bus.push && push_in && !push_acc) begin
            ovf_d[push_idx] = 1'b1;
        end
        if (bus.pop && pop_in && !pop_acc) begin
            unf_d[pop_idx] = 1'b1;
        end
        for (int c = CH - 1; c >= 0; c--) begin
            if (!empty_d[c]) begin
                sel_d = CHW'(c);
            end
        end
        any_ne_d = ~&empty_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= '0;
            end
            empty_q  <= '1;
            full_q   <= '0;
            ae_q     <= '1;
            af_q     <= '0;
            ovf_q    <= '0;
            unf_q    <= '0;
            any_ne_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            any_ne_q <= any_ne_d;
            sel_q    <= sel_d;
        end
    end

    always_comb begin
        bus.count = '0;
        for (int c = 0; c < CH; c++) begin
            bus.count[c*CW +: CW] = cnt_q[c];
        end
    end

    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.any_ne       = any_ne_q;
    assign bus.sel_ch       = sel_q;
endmodule

// File: tb/tb_queue_flag_tracker.sv
// tb/tb_queue_flag_tracker.sv - self-checking bench for queue_flag_tracker
module tb_queue_flag_tracker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    queue_flag_tracker_if #(.N(3), .CH(4)) bus();

    queue_flag_tracker #(.N(3), .CH(4), .AF_LVL(6), .AE_LVL(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] count;
        logic [3:0]  empty;
        logic [3:0]  full;
        logic [3:0]  ae;
        logic [3:0]  af;
        logic [3:0]  ovf;
        logic [3:0]  unf;
        logic        any_ne;
        logic [1:0]  sel;
    } st_t;

    st_t sb[$];
    int  checks = 0;
    int  failures = 0;

    int mcnt[4];
    bit movf[4];
    bit munf[4];

    function automatic st_t sample();
        st_t s;
        s.count  = bus.count;
        s.empty  = bus.empty;
        s.full   = bus.full;
        s.ae     = bus.almost_empty;
        s.af     = bus.almost_full;
        s.ovf    = bus.overflow;
        s.unf    = bus.underflow;
        s.any_ne = bus.any_ne;
        s.sel    = bus.sel_ch;
        return s;
    endfunction

    function automatic st_t model_state();
        st_t s;
        s = '0;
        s.sel = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            s.count[c*4 +: 4] = mcnt[c][3:0];
            s.empty[c] = (mcnt[c] == 0);
            s.full[c]  = (mcnt[c] == 8);
            s.ae[c]    = (mcnt[c] <= 1);
            s.af[c]    = (mcnt[c] >= 6);
            s.ovf[c]   = movf[c];
            s.unf[c]   = munf[c];
            if (mcnt[c] != 0) s.sel = 2'(c);
        end
        s.any_ne = (s.empty != 4'hF);
        return s;
    endfunction

    // Drives one cycle of stimulus, updates the reference model, and queues the
    // expected post-edge state. Returns expected and observed acceptance.
    task automatic drive(input bit r, input bit pu, input int puc, input bit po, input int poc,
                         input bit clr, output bit exp_ua, output bit exp_pa,
                         output bit obs_ua, output bit obs_pa);
        @(negedge clk);
        rst = r;
        bus.push = pu; bus.push_ch = 2'(puc);
        bus.pop = po;  bus.pop_ch = 2'(poc);
        bus.clr_err = clr;
        exp_pa = po && (mcnt[poc] > 0);
        exp_ua = pu && ((mcnt[puc] < 8) || (exp_pa && poc == puc));
        #1;
        obs_ua = bus.push_acc;
        obs_pa = bus.pop_acc;
        if (r) begin
            for (int c = 0; c < 4; c++) begin
                mcnt[c] = 0; movf[c] = 0; munf[c] = 0;
            end
        end else begin
            if (clr) for (int c = 0; c < 4; c++) begin movf[c] = 0; munf[c] = 0; end
            if (exp_ua) mcnt[puc]++;
            if (exp_pa) mcnt[poc]--;
            if (pu && !exp_ua) movf[puc] = 1;
            if (po && !exp_pa) munf[poc] = 1;
        end
        sb.push_back(model_state());
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        bit eu, ep, ou, op;
        st_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 0, 0, eu, ep, ou, op);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset cyc%0d state got=%h want=%h", i, o, e); end
        end
        checks++;
        if (bus.empty !== 4'b1111 || bus.almost_empty !== 4'b1111 || bus.count !== 16'h0 ||
            bus.full !== 4'b0 || bus.overflow !== 4'b0 || bus.underflow !== 4'b0 || bus.any_ne !== 1'b0) begin
            failures++;
            $display("FAIL reset values got empty=%b ae=%b count=%h full=%b any_ne=%b want 1111 1111 0 0 0",
                     bus.empty, bus.almost_empty, bus.count, bus.full, bus.any_ne);
        end
    endtask

    task automatic test_fill();
        bit eu, ep, ou, op;
        st_t e, o;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 2, 0, 0, 0, eu, ep, ou, op);
            checks++;
            if (ou !== 1'b1) begin failures++; $display("FAIL fill push_acc n=%0d got=%b want=1", i, ou); end
            if (sb.size() == 0) begin failures++; $display("FAIL fill scoreboard empty got=0 want=1"); end
            else begin
                e = sb.pop_front(); o = sample(); checks++;
                if (o !== e) begin failures++; $display("FAIL fill n=%0d state got=%h want=%h", i, o, e); end
            end
            checks++;
            if (bus.count[11:8] !== 4'(i) || bus.almost_empty[2] !== (i <= 1) ||
                bus.almost_full[2] !== (i >= 6) || bus.full[2] !== (i == 8)) begin
                failures++;
                $display("FAIL fill flags n=%0d got cnt=%0d ae=%b af=%b full=%b", i,
                         bus.count[11:8], bus.almost_empty[2], bus.almost_full[2], bus.full[2]);
            end
        end
        checks++;
        if (bus.sel_ch !== 2'd2 || bus.any_ne !== 1'b1) begin
            failures++; $display("FAIL fill sel got sel=%0d any=%b want sel=2 any=1", bus.sel_ch, bus.any_ne);
        end
    endtask

    task automatic test_overflow();
        bit eu, ep, ou, op;
        st_t e, o;
        drive(0, 1, 2, 0, 0, 0, eu, ep, ou, op);
        checks++;
        if (ou !== 1'b0 || eu !== 1'b0) begin failures++; $display("FAIL ovf push_acc got=%b want=0", ou); end
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin failures++; $display("FAIL ovf state got=%h want=%h", o, e); end
        checks++;
        if (bus.overflow !== 4'b0100 || bus.count[11:8] !== 4'd8) begin
            failures++; $display("FAIL ovf bits got ovf=%b cnt=%0d want 0100 8", bus.overflow, bus.count[11:8]);
        end
        drive(0, 1, 2, 1, 2, 0, eu, ep, ou, op);
        checks++;
        if (ou !== 1'b1 || op !== 1'b1) begin failures++; $display("FAIL full pushpop acc got=%b%b want=11", ou, op); end
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin failures++; $display("FAIL full pushpop state got=%h want=%h", o, e); end
        checks++;
        if (bus.count[11:8] !== 4'd8 || bus.overflow !== 4'b0100) begin
            failures++; $display("FAIL full pushpop got cnt=%0d ovf=%b want 8 0100", bus.count[11:8], bus.overflow);
        end
    endtask

    task automatic test_underflow();
        bit eu, ep, ou, op;
        st_t e, o;
        drive(0, 1, 0, 1, 0, 0, eu, ep, ou, op);
        checks++;
        if (op !== 1'b0 || ou !== 1'b1) begin failures++; $display("FAIL unf acc got pop=%b push=%b want 0 1", op, ou); end
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin failures++; $display("FAIL unf state got=%h want=%h", o, e); end
        checks++;
        if (bus.underflow[0] !== 1'b1 || bus.count[3:0] !== 4'd1 || bus.sel_ch !== 2'd0) begin
            failures++; $display("FAIL unf got unf=%b cnt0=%0d sel=%0d want x1 1 0", bus.underflow, bus.count[3:0], bus.sel_ch);
        end
    endtask

    task automatic test_clr_err();
        bit eu, ep, ou, op;
        st_t e, o;
        drive(0, 0, 0, 1, 3, 1, eu, ep, ou, op);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin failures++; $display("FAIL clr state got=%h want=%h", o, e); end
        checks++;
        if (bus.underflow !== 4'b1000 || bus.overflow !== 4'b0000) begin
            failures++; $display("FAIL clr bits got unf=%b ovf=%b want 1000 0000", bus.underflow, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit eu, ep, ou, op;
        st_t e, o;
        // Pop channel 2 while pushing channel 1 every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 1, 2, 0, eu, ep, ou, op);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b n=%0d state got=%h want=%h", i, o, e); end
        end
        checks++;
        if (bus.count[7:4] !== 4'd4 || bus.count[11:8] !== 4'd4) begin
            failures++; $display("FAIL b2b counts got c1=%0d c2=%0d want 4 4", bus.count[7:4], bus.count[11:8]);
        end
    endtask

    task automatic test_mid_reset();
        bit eu, ep, ou, op;
        st_t e, o;
        drive(1, 1, 2, 1, 0, 0, eu, ep, ou, op);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin failures++; $display("FAIL midrst state got=%h want=%h", o, e); end
        checks++;
        if (bus.count !== 16'h0 || bus.empty !== 4'hF || bus.any_ne !== 1'b0 || bus.sel_ch !== 2'd0 ||
            bus.underflow !== 4'h0) begin
            failures++; $display("FAIL midrst got count=%h empty=%b any=%b sel=%0d", bus.count, bus.empty, bus.any_ne, bus.sel_ch);
        end
    endtask

    initial begin
        bus.push = 1'b0; bus.push_ch = '0;
        bus.pop = 1'b0;  bus.pop_ch = '0;
        bus.clr_err = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_clr_err();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard leftover got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
